mvm_result_reader: RTL
======================

Name: mvm_result_reader

Overview:
- Output-side reader for the matrix-vector block: accepts 16-bit result elements from the MAC datapath and buffers them in a small FIFO.
- Re-emits the elements on a valid/ready output stream with back-pressure.
- Marks the last element of each result vector and pulses a per-vector completion strobe.
- Sits between the accumulator output and the downstream consumer that drives m_ready.

Parameters:
- DATA_W, 16, width of each result element
- VEC_LEN, 3, elements per result vector (rows of M)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush of FIFO and element counter
- in_valid  in  1  result element valid from datapath
- in_ready  out  1  reader can accept an element
- in_data  in  DATA_W  result element
- m_valid  out  1  output element valid
- m_ready  in  1  consumer accepts output element
- m_data  out  DATA_W  output element (FIFO head)
- m_last  out  1  current output element is element VEC_LEN-1 of its vector
- vec_done  out  1  one-cycle pulse after last element of a vector transfers
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, level=0, elem_cnt=0, vec_done=0, m_valid=0, m_last=0, in_ready=1, m_data=0.
- Input handshake: push when in_valid && in_ready at rising edge.
  - in_ready = (level != DEPTH); combinational from level only, never from m_ready. A full FIFO does not accept a push even if a pop happens in the same cycle.
- Output handshake: pop when m_valid && m_ready at rising edge.
  - m_valid = (level != 0).
  - m_data = mem[rd_ptr], show-ahead; m_data = 0 when empty.
- Latency: element pushed at edge k appears on m_data/m_valid after edge k (one cycle). No combinational in->out path.
- Simultaneous push and pop (level between 1 and DEPTH-1): both pointers advance, level unchanged.
- Push only: level+1. Pop only: level-1. Pointers wrap modulo DEPTH.
- m_valid must hold, and m_data must stay stable, until the pop; the consumer may stall indefinitely.
- Element counter elem_cnt (0..VEC_LEN-1):
  - Increments on each pop; wraps to 0 after VEC_LEN-1.
  - m_last = m_valid && (elem_cnt == VEC_LEN-1).
- vec_done: registered; =1 for exactly one cycle after the edge at which a pop occurs with elem_cnt == VEC_LEN-1; else 0.
- clr=1 (synchronous, priority over push/pop):
  - Next edge: pointers=0, level=0, elem_cnt=0, vec_done=0.
  - in_valid is ignored in that cycle; memory contents need not be cleared.
- Reset mid-stream: all state returns to reset values immediately; partially transferred vectors are discarded.
- in_valid while full: element is not accepted; the datapath must hold it.
- m_ready while empty: no effect.
- Outputs are never X after reset is released.

Test Plan:
- Reset then idle: release reset -> m_valid=0, in_ready=1, level=0, m_last=0, vec_done=0 for 10 cycles.
- Single vector, m_ready=1: push 10, 20, 30 on consecutive edges -> m_data 10, 20, 30 one cycle later each; m_last=1 only on 30; vec_done high exactly one cycle after the edge at which 30 transfers.
- Fill and back-pressure: m_ready=0, push 1..5 -> 1..4 accepted, level=4, in_ready=0, 5 held. Raise m_ready -> outputs 1, 2, 3, 4, 5 in order; m_last on 3; a second m_last on the 3rd element of the next vector (6th element overall) once it is pushed and transferred.
- Simultaneous push/pop at level=2: hold in_valid=1 and m_ready=1 for 6 cycles -> level stays 2, output order equals input order across pointer wrap.
- clr mid-vector: after 1 of 3 elements popped with 2 buffered, assert clr for one cycle -> level=0, m_valid=0, elem_cnt=0. Next pushes 7, 8, 9 -> m_last on 9.
- Async reset mid-transfer: drop reset between edges with level=3 -> m_valid falls immediately, level=0; after release, normal operation resumes from elem_cnt=0.

Source files
------------

// File: rtl/mvm_result_reader.sv
// rtl/mvm_result_reader.sv - result FIFO with vector framing between MAC output and consumer
// Show-ahead FIFO; elem_cnt tracks position within the current output vector.
module mvm_result_reader #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 3,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     vec_done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     elem_cnt;
  logic              push;
  logic              pop;
  logic              cnt_last;

  // in_ready looks only at level, so a full FIFO refuses a push even when popping.
  assign in_ready = (level != LW'(DEPTH));
  assign m_valid  = (level != '0);
  assign m_data   = m_valid ? mem[rd_ptr] : '0;
  assign cnt_last = (elem_cnt == CW'(VEC_LEN - 1));
  assign m_last   = m_valid && cnt_last;
  assign push     = in_valid && in_ready && !clr;
  assign pop      = m_valid && m_ready && !clr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      elem_cnt <= '0;
      vec_done <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      elem_cnt <= '0;
      vec_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        elem_cnt <= cnt_last ? '0 : elem_cnt + CW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      vec_done <= pop && cnt_last;
    end
  end

endmodule
